// File: rtl/beta_alu_pkg.sv
// Shared Beta ALU definitions: 4-bit function codes and the multiply
// sequencer state encoding.
package beta_alu_pkg;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_MUL   = 4'b0010;
   localparam logic [3:0] ALU_CMPEQ = 4'b0100;
   localparam logic [3:0] ALU_CMPLT = 4'b0101;
   localparam logic [3:0] ALU_CMPLE = 4'b0110;
   localparam logic [3:0] ALU_AND   = 4'b1000;
   localparam logic [3:0] ALU_OR    = 4'b1001;
   localparam logic [3:0] ALU_XOR   = 4'b1010;
   localparam logic [3:0] ALU_XNOR  = 4'b1011;
   localparam logic [3:0] ALU_SHL   = 4'b1100;
   localparam logic [3:0] ALU_SHR   = 4'b1101;
   localparam logic [3:0] ALU_SRA   = 4'b1110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

endpackage

// File: rtl/beta_mul_sequencer_if.sv
// Multiply request/response bundle between the datapath (master) and the
// iterative multiply sequencer (slave).
interface beta_mul_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             mul_start;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   modport master (
      output mul_start, mul_a, mul_b,
      input  mul_busy, mul_done, mul_product
   );

   modport slave (
      input  mul_start, mul_a, mul_b,
      output mul_busy, mul_done, mul_product
   );
endinterface

// File: rtl/beta_mul_sequencer.sv
// Shift-and-add multiply controller that borrows the shared Beta ALU's ADD
// function, one partial product per cycle, stalling the datapath meanwhile.
module beta_mul_sequencer
   import beta_alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0]             dp_fn,
   input  logic [WIDTH-1:0]       dp_a,
   input  logic [WIDTH-1:0]       dp_b,
   output logic [WIDTH-1:0]       dp_result,
   beta_mul_sequencer_if.slave    mul,
   output logic                   stall,
   output logic [3:0]             alu_fn,
   output logic [WIDTH-1:0]       alu_a,
   output logic [WIDTH-1:0]       alu_b,
   input  logic [WIDTH-1:0]       alu_result
);

   seq_state_e       state_q,   state_d;
   logic [WIDTH-1:0] acc_q,     acc_d;
   logic [WIDTH-1:0] mcand_q,   mcand_d;
   logic [WIDTH-1:0] mplier_q,  mplier_d;
   logic [CNT_W-1:0] count_q,   count_d;
   logic [WIDTH-1:0] product_q, product_d;
   logic             last_iter_s;

   // State and operand registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   // Stop once no multiplier bits remain, or after the last bit position
   assign last_iter_s = ((mplier_q >> 1) == '0) || (count_q == CNT_W'(WIDTH - 1));

   // Next-state logic and ALU port multiplexing
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      count_d   = count_q;
      product_d = product_q;
      alu_fn    = dp_fn;
      alu_a     = dp_a;
      alu_b     = dp_b;
      case (state_q)
         ST_IDLE: begin
            if (mul.mul_start) begin
               mcand_d  = mul.mul_a;
               mplier_d = mul.mul_b;
               acc_d    = '0;
               count_d  = '0;
               if (mul.mul_b != '0) begin
                  state_d = ST_RUN;
               end else begin
                  state_d   = ST_DONE;
                  product_d = '0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            alu_fn   = ALU_ADD;
            alu_a    = acc_q;
            alu_b    = mplier_q[0] ? mcand_q : '0;
            acc_d    = alu_result;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CNT_W'(1);
            if (last_iter_s) begin
               state_d   = ST_DONE;
               product_d = alu_result;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign dp_result       = alu_result;
   assign stall           = (state_q == ST_RUN);
   assign mul.mul_busy    = (state_q != ST_IDLE);
   assign mul.mul_done    = (state_q == ST_DONE);
   assign mul.mul_product = product_q;

endmodule

// File: tb/tb_beta_mul_sequencer.sv
// Scoreboard bench for beta_mul_sequencer with a behavioural ALU beside it.
module tb_beta_mul_sequencer;
   import beta_alu_pkg::*;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] product;
      int           done_cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [3:0]    dp_fn = 4'b0000;
   logic [W-1:0]  dp_a = '0;
   logic [W-1:0]  dp_b = '0;
   logic [W-1:0]  dp_result;
   logic          stall;
   logic [3:0]    alu_fn;
   logic [W-1:0]  alu_a, alu_b, alu_result;

   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   exp_t sb_q[$];

   beta_mul_sequencer_if #(.WIDTH(W)) mul_if_i ();

   beta_mul_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .dp_fn      (dp_fn),
      .dp_a       (dp_a),
      .dp_b       (dp_b),
      .dp_result  (dp_result),
      .mul        (mul_if_i.slave),
      .stall      (stall),
      .alu_fn     (alu_fn),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference ALU: only the functions exercised here are modelled
   always_comb begin
      case (alu_fn)
         ALU_ADD: alu_result = alu_a + alu_b;
         ALU_SUB: alu_result = alu_a - alu_b;
         ALU_AND: alu_result = alu_a & alu_b;
         ALU_OR:  alu_result = alu_a | alu_b;
         ALU_XOR: alu_result = alu_a ^ alu_b;
         default: alu_result = '0;
      endcase
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && mul_if_i.mul_done) begin
            if (sb_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got pulse expected none (cycle %0d)", cyc);
            end else begin
               e = sb_q.pop_front();
               check("product", mul_if_i.mul_product, e.product);
               check("done_cycle", W'(cyc), W'(e.done_cyc));
            end
         end
      end
   endtask

   // Issues a one-cycle start; returns during the first cycle after acceptance
   task automatic issue_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] prod, input int n, input bit expect_done);
      exp_t e;
      @(posedge clk); #1;
      mul_if_i.mul_start = 1'b1;
      mul_if_i.mul_a     = a;
      mul_if_i.mul_b     = b;
      if (expect_done) begin
         e.product  = prod;
         e.done_cyc = cyc + 1 + n;
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
      mul_if_i.mul_start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (mul_if_i.mul_busy && k < 80) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 80) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got busy expected idle within 80 cycles", name);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      bit saw_stall;
      mul_if_i.mul_start = 1'b0;
      mul_if_i.mul_a     = '0;
      mul_if_i.mul_b     = '0;
      fork
         monitor_loop();
      join_none

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_busy",    W'(mul_if_i.mul_busy), W'(0));
      check("rst_done",    W'(mul_if_i.mul_done), W'(0));
      check("rst_stall",   W'(stall), W'(0));
      check("rst_product", mul_if_i.mul_product, W'(0));

      dp_fn = ALU_SUB; dp_a = 32'd10; dp_b = 32'd3;
      @(negedge clk);
      check("pt_fn",     W'(alu_fn), W'(4'b0001));
      check("pt_a",      alu_a, 32'd10);
      check("pt_b",      alu_b, 32'd3);
      check("pt_result", dp_result, 32'd7);
      check("pt_stall",  W'(stall), W'(0));

      // 6*7: three RUN cycles then DONE, busy clears the cycle after
      issue_mul(32'd6, 32'd7, 32'd42, 3, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("run_stall", W'(stall), W'(1));
      end
      @(negedge clk);
      check("done_stall", W'(stall), W'(0));
      @(negedge clk);
      check("after_busy", W'(mul_if_i.mul_busy), W'(0));

      // Zero multiplier goes straight to DONE without stalling
      issue_mul(32'h1234_5678, 32'd0, 32'd0, 0, 1'b1);
      saw_stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (stall) saw_stall = 1'b1;
      end
      check("zero_nostall", W'(saw_stall), W'(0));

      issue_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32, 1'b1);
      wait_idle("allones");
      issue_mul(32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 5, 1'b1);
      wait_idle("shift16");
      issue_mul(32'd5, 32'd9, 32'd45, 4, 1'b1);
      wait_idle("gap9");
      issue_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 2, 1'b1);
      wait_idle("neg2");

      // Start re-pulsed mid-operation must be ignored
      issue_mul(32'd6, 32'd7, 32'd42, 3, 1'b1);
      mul_if_i.mul_start = 1'b1;
      mul_if_i.mul_a     = 32'd1;
      mul_if_i.mul_b     = 32'd1;
      @(posedge clk); #1;
      mul_if_i.mul_start = 1'b0;
      wait_idle("repulse");

      // Abort with reset: move product away from 0 first so the clear is visible
      issue_mul(32'd3, 32'd3, 32'd9, 2, 1'b1);
      wait_idle("pre_abort");
      issue_mul(32'd6, 32'd7, 32'd0, 3, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      dp_fn = ALU_XOR; dp_a = 32'h0000_00F0; dp_b = 32'h0000_00FF;
      @(negedge clk);
      check("abort_busy",    W'(mul_if_i.mul_busy), W'(0));
      check("abort_product", mul_if_i.mul_product, W'(0));
      check("abort_stall",   W'(stall), W'(0));
      check("abort_fn",      W'(alu_fn), W'(4'b1010));
      check("abort_result",  dp_result, 32'h0000_000F);
      repeat (6) @(negedge clk);

      check("sb_empty", W'(sb_q.size()), W'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/beta_mul_sequencer.md
Name: beta_mul_sequencer

Overview:
Iterative multiply controller that shares the single Beta ALU with the main datapath.
- When idle, the ALU ports are a transparent pass-through from the datapath.
- On a multiply request, the block takes the ALU over and runs a shift-and-add loop using the ALU ADD function, one partial-product addition per cycle.
- It stalls the datapath while it holds the ALU. This is how MUL is provided without a combinational multiplier in the ALU.

Parameters:
WIDTH, 32, operand/result width; must match the ALU.
CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
dp_fn  in  4  datapath ALU function code.
dp_a  in  WIDTH  datapath ALU operand A.
dp_b  in  WIDTH  datapath ALU operand B.
dp_result  out  WIDTH  ALU result returned to datapath; equals alu_result; valid only when stall=0.
mul_start  in  1  single-cycle multiply request; accepted only in IDLE.
mul_a  in  WIDTH  multiplicand, sampled with an accepted mul_start.
mul_b  in  WIDTH  multiplier, sampled with an accepted mul_start.
mul_busy  out  1  high whenever state != IDLE.
mul_done  out  1  one-cycle pulse; mul_product is valid in that cycle.
mul_product  out  WIDTH  low WIDTH bits of mul_a*mul_b; held until the next accepted start.
stall  out  1  high in RUN only; datapath must not issue ALU work.
alu_fn  out  4  to ALU AluFn.
alu_a  out  WIDTH  to ALU InA.
alu_b  out  WIDTH  to ALU InB.
alu_result  in  WIDTH  from ALU Result (combinational ALU).

Behaviour:
- States are IDLE, RUN and DONE.
- Reset values: state=IDLE, mul_busy=0, mul_done=0, stall=0, mul_product=0; acc, mcand, mplier and count all 0.
- IDLE:
  - alu_fn/a/b = dp_fn/a/b.
  - On mul_start: mcand<=mul_a, mplier<=mul_b, acc<=0, count<=0.
  - Next state is RUN if mul_b!=0; otherwise DONE with mul_product<=0.
- RUN:
  - Drives alu_fn=ADD (4'b0000), alu_a=acc, alu_b = mplier[0] ? mcand : 0.
  - Each cycle: acc<=alu_result, mcand<=mcand<<1, mplier<=mplier>>1, count<=count+1.
  - Exit to DONE when (mplier>>1)==0 or count==WIDTH-1; mul_product<=alu_result on exit.
- DONE:
  - Exactly one cycle; mul_done=1. ALU ports return to pass-through. Next state IDLE.
- Latency: accepted start at cycle t. N = index of the most-significant set bit of mul_b, plus 1 (N=0 when mul_b=0). mul_done is high at cycle t+1+N. Maximum is t+1+WIDTH.
- Arithmetic: all additions wrap modulo 2^WIDTH. Only the low WIDTH bits are produced, which is identical for signed and unsigned operands.
- mul_start while mul_busy=1 is ignored, including in DONE. No queueing; the operands are not resampled.
- dp inputs are ignored in RUN. dp_result carries sequencer sums then and must be discarded (stall=1).
- reset asserted in any state, including mid-RUN: all registers return to reset values on that edge. No mul_done pulse is produced for the aborted operation.
- mul_product updates only on RUN/zero-operand exit. It is stable in DONE and IDLE.

Decomposition:
- Shared package beta_alu_pkg:
  - 4-bit ALU function constants: ADD 0000, SUB 0001, MUL 0010, CMPEQ 0100, CMPLT 0101, CMPLE 0110, AND 1000, OR 1001, XOR 1010, XNOR 1011, SHL 1100, SHR 1101, SRA 1110.
  - The sequencer state enum (IDLE/RUN/DONE).
- The ALU itself is instantiated beside this block at the next level up, not inside it.
- No sub-module; the ALU-port mux and the FSM stay in one module.

Test Plan:
- IDLE pass-through: dp_fn=SUB, dp_a=10, dp_b=3 -> alu_fn=0001, alu_a=10, alu_b=3, dp_result=7, stall=0.
- mul_start at cycle 0, mul_a=6, mul_b=7 -> stall high cycles 1-3; mul_done=1 at cycle 4; mul_product=42; mul_busy low at cycle 5.
- mul_a=0x12345678, mul_b=0 -> mul_done at cycle 1, mul_product=0, stall never high.
- mul_a=mul_b=0xFFFFFFFF -> 32 RUN cycles; mul_done at cycle 33; mul_product=0x00000001.
- mul_start re-pulsed at cycle 2 with mul_a=1, mul_b=1 during a 6*7 operation -> ignored; product still 42 at cycle 4.
- reset at cycle 2 of a 6*7 operation -> cycle 3: IDLE, mul_busy=0, mul_product=0, no mul_done pulse; ALU back in pass-through.
